// File: rtl/cnn_ofmap_serializer_pkg.sv
// Shared geometry of the CNN output feature map and its flat packing order.
// Core, input loader and serializer all import this so element order lives in one place.
package cnn_ofmap_serializer_pkg;

  localparam int unsigned CNN_OCH      = 32'd2;
  localparam int unsigned CNN_OX       = 32'd4;
  localparam int unsigned CNN_OY       = 32'd4;
  localparam int unsigned CNN_DATA_LEN = 32'd16;
  localparam int unsigned CNN_TOTAL    = CNN_OCH * CNN_OX * CNN_OY;

  // Width of an index over n items, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    if (w < 32'd1) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  // Flat element index: channel-major, then row, then column.
  function automatic int unsigned elem_index(input int unsigned och,
                                             input int unsigned y,
                                             input int unsigned x);
    return och * CNN_OX * CNN_OY + y * CNN_OX + x;
  endfunction

endpackage

// File: rtl/cnn_ofmap_serializer_word_mux.sv
// Combinational N:1 selector of W-bit words from a flat bus, indexed by sel.
// Out-of-range selects yield zero rather than X.
module cnn_word_mux #(
  parameter int unsigned N     = 32'd32,
  parameter int unsigned W     = 32'd16,
  parameter int unsigned SEL_W = 32'd5
) (
  input  logic [N*W-1:0]   words,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     word
);

  // AND-OR selection keeps the structure flat and free of priority chains.
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < N; i++) begin
      word = word | (words[i*W +: W] & {W{sel == SEL_W'(i)}});
    end
  end

endmodule

// File: rtl/cnn_ofmap_serializer.sv
// Captures one flat output feature map on a valid pulse and streams it out
// one element per valid/ready handshake, flagging maps dropped while busy.
module cnn_ofmap_serializer
  import cnn_ofmap_serializer_pkg::*;
#(
  parameter int unsigned OCH      = CNN_OCH,
  parameter int unsigned OX       = CNN_OX,
  parameter int unsigned OY       = CNN_OY,
  parameter int unsigned DATA_LEN = CNN_DATA_LEN
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              i_soft_reset,
  input  logic                              i_in_valid,
  input  logic [OCH*OX*OY*DATA_LEN-1:0]     i_in_fmap,
  output logic                              o_ot_valid,
  output logic [DATA_LEN-1:0]               o_ot_data,
  output logic                              o_ot_last,
  output logic [clog2_min1(OCH)-1:0]        o_ot_och,
  input  logic                              i_ot_ready,
  output logic                              o_busy,
  output logic                              o_overflow
);

  localparam int unsigned TOTAL = OCH * OX * OY;
  localparam int unsigned PLANE = OX * OY;
  localparam int unsigned CNT_W = clog2_min1(TOTAL);
  localparam int unsigned OCH_W = clog2_min1(OCH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e                     state_r;
  logic [CNT_W-1:0]           count_r;
  logic [TOTAL*DATA_LEN-1:0]  buf_r;
  logic                       valid_r;
  logic                       busy_r;
  logic                       overflow_r;

  logic                       xfer_s;
  logic                       last_s;
  logic [DATA_LEN-1:0]        word_s;
  logic [31:0]                och_idx_s;

  cnn_word_mux #(
    .N     (TOTAL),
    .W     (DATA_LEN),
    .SEL_W (CNT_W)
  ) u_word_mux (
    .words (buf_r),
    .sel   (count_r),
    .word  (word_s)
  );

  // Handshake decode and stream outputs, forced to zero outside DRAIN.
  always_comb begin
    xfer_s    = valid_r & i_ot_ready;
    last_s    = (count_r == CNT_W'(TOTAL - 32'd1));
    och_idx_s = 32'(count_r) / 32'(PLANE);
    if (valid_r) begin
      o_ot_data = word_s;
      o_ot_last = last_s;
      o_ot_och  = OCH_W'(och_idx_s);
    end else begin
      o_ot_data = '0;
      o_ot_last = 1'b0;
      o_ot_och  = '0;
    end
  end

  // Capture/drain FSM; valid, busy and overflow are registered alongside state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      count_r    <= '0;
      buf_r      <= '0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else if (i_soft_reset) begin
      state_r    <= ST_IDLE;
      count_r    <= '0;
      buf_r      <= '0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_in_valid) begin
            buf_r   <= i_in_fmap;
            count_r <= '0;
            state_r <= ST_DRAIN;
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (xfer_s && last_s) begin
            count_r <= '0;
            // A pulse coinciding with the final handshake reloads without a bubble.
            if (i_in_valid) begin
              buf_r <= i_in_fmap;
            end else begin
              state_r <= ST_IDLE;
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
            end
          end else begin
            if (xfer_s) begin
              count_r <= count_r + CNT_W'(1);
            end
            if (i_in_valid) begin
              overflow_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          count_r    <= '0;
          valid_r    <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign o_ot_valid = valid_r;
  assign o_busy     = busy_r;
  assign o_overflow = overflow_r;

endmodule

// File: tb/tb_cnn_ofmap_serializer.sv
// Scoreboard bench for cnn_ofmap_serializer: directed maps push expected words,
// a negedge monitor pops and compares every accepted word and checks stall stability.
module tb_cnn_ofmap_serializer;
  import cnn_ofmap_serializer_pkg::*;

  localparam int unsigned TOTAL = CNN_TOTAL;
  localparam int unsigned DL    = CNN_DATA_LEN;

  logic                  clk;
  logic                  reset_n;
  logic                  i_soft_reset;
  logic                  i_in_valid;
  logic [TOTAL*DL-1:0]   i_in_fmap;
  logic                  o_ot_valid;
  logic [DL-1:0]         o_ot_data;
  logic                  o_ot_last;
  logic [0:0]            o_ot_och;
  logic                  i_ot_ready;
  logic                  o_busy;
  logic                  o_overflow;

  int n_vec;
  int n_err;
  logic [17:0] exp_q[$];

  cnn_ofmap_serializer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_soft_reset (i_soft_reset),
    .i_in_valid   (i_in_valid),
    .i_in_fmap    (i_in_fmap),
    .o_ot_valid   (o_ot_valid),
    .o_ot_data    (o_ot_data),
    .o_ot_last    (o_ot_last),
    .o_ot_och     (o_ot_och),
    .i_ot_ready   (i_ot_ready),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected word per accepted transfer and checks stalls hold.
  logic        pv, pr, pl;
  logic [15:0] pd;
  logic [0:0]  po;
  initial begin
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 16'h0; po = 1'b0;
  end
  always @(negedge clk) begin
    logic [17:0] e;
    if (pv && !pr && o_ot_valid) begin
      chk("stall_data", 32'(o_ot_data), 32'(pd));
      chk("stall_last", 32'(o_ot_last), 32'(pl));
      chk("stall_och",  32'(o_ot_och),  32'(po));
    end
    if (o_ot_valid && i_ot_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %0h expected no word at %0t", o_ot_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", 32'(o_ot_data), 32'(e[15:0]));
        chk("word_och",  32'(o_ot_och),  32'(e[16]));
        chk("word_last", 32'(o_ot_last), 32'(e[17]));
      end
    end
    pv = o_ot_valid; pr = i_ot_ready; pd = o_ot_data; pl = o_ot_last; po = o_ot_och;
  end

  task automatic do_pulse(input logic [15:0] base, input bit push);
    logic [TOTAL*DL-1:0] fm;
    int unsigned k;
    fm = '0;
    for (int c = 0; c < int'(CNN_OCH); c++)
      for (int y = 0; y < int'(CNN_OY); y++)
        for (int x = 0; x < int'(CNN_OX); x++) begin
          k = elem_index(c, y, x);
          fm[k*DL +: DL] = base + 16'(k);
        end
    if (push) begin
      for (int i = 0; i < int'(TOTAL); i++)
        exp_q.push_back({(i == int'(TOTAL) - 1), 1'(i / 16), base + 16'(i)});
    end
    i_in_fmap  = fm;
    i_in_valid = 1'b1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
  endtask

  task automatic run_drain(input logic [3:0] pattern, output int cyc);
    cyc = 0;
    while (cyc < 400) begin
      i_ot_ready = pattern[cyc % 4];
      @(posedge clk); #1;
      cyc++;
      if (!o_busy) break;
    end
    i_ot_ready = 1'b1;
    chk("drain_done_busy", 32'(o_busy), 32'd0);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},    32'(o_ot_valid), 32'd0);
    chk({tag, "_data"},     32'(o_ot_data),  32'd0);
    chk({tag, "_last"},     32'(o_ot_last),  32'd0);
    chk({tag, "_och"},      32'(o_ot_och),   32'd0);
    chk({tag, "_busy"},     32'(o_busy),     32'd0);
    chk({tag, "_overflow"}, 32'(o_overflow), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    n_vec = 0; n_err = 0;
    reset_n = 1'b0; i_soft_reset = 1'b0; i_in_valid = 1'b0;
    i_in_fmap = '0; i_ot_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("post_reset");

    // Map k+1, ready high: 1-cycle latency, 32 consecutive words.
    chk("pre_pulse_valid", 32'(o_ot_valid), 32'd0);
    do_pulse(16'h0001, 1'b1);
    chk("latency_valid", 32'(o_ot_valid), 32'd1);
    chk("latency_busy",  32'(o_busy),     32'd1);
    chk("first_word",    32'(o_ot_data),  32'h0001);
    run_drain(4'b1111, cyc);
    chk("drain_cycles", 32'(cyc), 32'd32);
    chk("idle_valid", 32'(o_ot_valid), 32'd0);

    // Ready 1,0,0,1: stalls hold, all words in order.
    do_pulse(16'h0100, 1'b1);
    run_drain(4'b1001, cyc);
    chk("stall_drain_cycles", 32'(cyc), 32'd64);

    // Seamless reload on the final handshake.
    do_pulse(16'h0200, 1'b1);
    repeat (31) @(posedge clk);
    #1 do_pulse(16'hA000, 1'b1);
    chk("reload_valid", 32'(o_ot_valid), 32'd1);
    chk("reload_data",  32'(o_ot_data),  32'hA000);
    chk("reload_ovf",   32'(o_overflow), 32'd0);
    run_drain(4'b1111, cyc);
    chk("reload_ovf_end", 32'(o_overflow), 32'd0);

    // Dropped map while word 10 pending.
    do_pulse(16'h0001, 1'b1);
    repeat (9) @(posedge clk);
    #1 do_pulse(16'hB000, 1'b0);
    chk("ovf_set",       32'(o_overflow), 32'd1);
    chk("ovf_next_word", 32'(o_ot_data),  32'd11);
    run_drain(4'b1111, cyc);
    chk("ovf_sticky", 32'(o_overflow), 32'd1);

    // Soft reset at word 5, colliding with a pulse; then a fresh map.
    do_pulse(16'h0300, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("sr_pending_data", 32'(o_ot_data), 32'h0304);
    i_ot_ready = 1'b0; i_soft_reset = 1'b1; i_in_valid = 1'b1;
    @(posedge clk); #1;
    i_soft_reset = 1'b0; i_in_valid = 1'b0; i_ot_ready = 1'b1;
    exp_q.delete();
    chk_all_zero("soft_reset");
    @(posedge clk); #1;
    do_pulse(16'hC000, 1'b1);
    chk("sr_new_first", 32'(o_ot_data), 32'hC000);
    run_drain(4'b1111, cyc);

    // Asynchronous reset mid-drain.
    do_pulse(16'h0400, 1'b1);
    repeat (6) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk_all_zero("async_release");
    do_pulse(16'h0500, 1'b1);
    chk("ar_new_first", 32'(o_ot_data), 32'h0500);
    run_drain(4'b1001, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
